// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback arbiter and its load queue.
package wb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic                  live;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } lq_entry_t;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_port_t;

    // A valid ALU result to a non-zero register supersedes any load to the same rd.
    function automatic logic alu_kills(input logic                  valid,
                                       input logic [REG_ADDR_W-1:0] alu_rd,
                                       input logic [REG_ADDR_W-1:0] rd);
        return valid && (alu_rd != '0) && (alu_rd == rd);
    endfunction
endpackage

// File: rtl/wb_load_queue.sv
// In-order load result queue with ALU kill compare, up to two pops per cycle
// and a scoreboard of live destinations.
// Optional: WB_PENDING_MASK_EN enables the pending_mask decode; otherwise it is 0.
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu1_valid,
    input  logic [REG_ADDR_W-1:0]        alu1_rd,
    input  logic                         alu2_valid,
    input  logic [REG_ADDR_W-1:0]        alu2_rd,
    input  logic                         ld_valid,
    input  logic [REG_ADDR_W-1:0]        ld_rd,
    input  logic [XLEN-1:0]              ld_data,
    output logic                         ld_ready,
    output wb_port_t                     pop0,
    output wb_port_t                     pop1,
    output logic [31:0]                  pending_mask,
    output logic [$clog2(LQ_DEPTH):0]    count
);
    localparam int PW = $clog2(LQ_DEPTH);
    localparam int CW = PW + 1;

    lq_entry_t         mem     [LQ_DEPTH];
    lq_entry_t         mem_nxt [LQ_DEPTH];
    logic [PW-1:0]     head, tail, head1;
    logic [CW-1:0]     count_nxt;
    logic [1:0]        n_free, n_pop;
    logic              push, push_live;
    lq_entry_t         e0, e1;

    assign ld_ready = (count < CW'(LQ_DEPTH));

    // Pop selection, kill application and next queue contents.
    always_comb begin
        n_free = 2'd2 - {1'b0, alu1_valid} - {1'b0, alu2_valid};
        n_pop  = (count < CW'(n_free)) ? count[1:0] : n_free;
        head1  = head + 1'b1;
        e0     = mem[head];
        e1     = mem[head1];
        pop0   = '0;
        pop1   = '0;
        // A popped entry whose rd an ALU writes this same cycle is older, so it must not write.
        if (n_pop >= 2'd1 && e0.live && !alu_kills(alu1_valid, alu1_rd, e0.rd)
                          && !alu_kills(alu2_valid, alu2_rd, e0.rd))
            pop0 = '{we: 1'b1, rd: e0.rd, data: e0.data};
        if (n_pop == 2'd2 && e1.live && !alu_kills(alu1_valid, alu1_rd, e1.rd)
                          && !alu_kills(alu2_valid, alu2_rd, e1.rd))
            pop1 = '{we: 1'b1, rd: e1.rd, data: e1.data};

        push      = ld_valid && ld_ready && (ld_rd != '0);
        push_live = !alu_kills(alu1_valid, alu1_rd, ld_rd) && !alu_kills(alu2_valid, alu2_rd, ld_rd);
        count_nxt = count - CW'(n_pop) + CW'(push);

        for (int i = 0; i < LQ_DEPTH; i++) begin
            mem_nxt[i] = mem[i];
            if (alu_kills(alu1_valid, alu1_rd, mem[i].rd) || alu_kills(alu2_valid, alu2_rd, mem[i].rd))
                mem_nxt[i].live = 1'b0;
            if ((n_pop >= 2'd1 && PW'(i) == head) || (n_pop == 2'd2 && PW'(i) == head1))
                mem_nxt[i].live = 1'b0;
        end
        // Push never lands on a slot being popped: pushes are only accepted when not full.
        if (push)
            mem_nxt[tail] = '{live: push_live, rd: ld_rd, data: ld_data};
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LQ_DEPTH; i++) mem[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < LQ_DEPTH; i++) mem[i] <= mem_nxt[i];
            head  <= head + PW'(n_pop);
            tail  <= tail + PW'(push);
            count <= count_nxt;
        end
    end

`ifdef WB_PENDING_MASK_EN
    logic [31:0] mask_nxt;

    // Scoreboard of live destinations after this edge.
    always_comb begin
        mask_nxt = '0;
        for (int i = 0; i < LQ_DEPTH; i++)
            if (mem_nxt[i].live) mask_nxt[mem_nxt[i].rd] = 1'b1;
    end

    // Registered scoreboard export.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_mask <= '0;
        else     pending_mask <= mask_nxt;
    end
`else
    assign pending_mask = '0;
`endif
endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: ALU1 owns write port 1, ALU2 owns port 2; buffered loads
// fill the ports the ALUs leave idle, oldest first.
// Optional: WB_PENDING_MASK_EN enables the pending_mask scoreboard.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alu1_valid,
    input  logic [4:0]                alu1_rd,
    input  logic [31:0]               alu1_data,
    input  logic                      alu2_valid,
    input  logic [4:0]                alu2_rd,
    input  logic [31:0]               alu2_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [4:0]                ld_rd,
    input  logic [31:0]               ld_data,
    output logic                      reg_write,
    output logic [4:0]                regd,
    output logic [31:0]               write_data,
    output logic                      reg_write2,
    output logic [4:0]                regd2,
    output logic [31:0]               write_data2,
    output logic [31:0]               pending_mask,
    output logic [$clog2(LQ_DEPTH):0] lq_count
);
    wb_port_t pop0, pop1, port1_nxt, port2_nxt;

    wb_load_queue #(.LQ_DEPTH(LQ_DEPTH)) u_lq (
        .clk          (clk),
        .rst          (rst),
        .alu1_valid   (alu1_valid),
        .alu1_rd      (alu1_rd),
        .alu2_valid   (alu2_valid),
        .alu2_rd      (alu2_rd),
        .ld_valid     (ld_valid),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .pop0         (pop0),
        .pop1         (pop1),
        .pending_mask (pending_mask),
        .count        (lq_count)
    );

    // Port assignment: live pops go to the lowest free port, head first.
    always_comb begin
        port1_nxt = alu1_valid ? '{we: 1'b1, rd: alu1_rd, data: alu1_data}
                  : (pop0.we ? pop0 : pop1);
        if (alu2_valid)      port2_nxt = '{we: 1'b1, rd: alu2_rd, data: alu2_data};
        else if (alu1_valid) port2_nxt = pop0;
        else if (pop0.we)    port2_nxt = pop1;
        else                 port2_nxt = '0;
    end

    // Registered write ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {reg_write,  regd,  write_data}  <= '0;
            {reg_write2, regd2, write_data2} <= '0;
        end else begin
            {reg_write,  regd,  write_data}  <= port1_nxt;
            {reg_write2, regd2, write_data2} <= port2_nxt;
        end
    end
endmodule
